booth_seq_mul16: RTL and testbench



---
 rtl/booth_seq_mul16.sv | 127 ++++++++++++
 tb/tb_booth_seq_mul16.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul16.sv
// Iterative radix-4 Booth 16x16 multiplier, one Booth group per cycle.
// Signed/unsigned operands, 32-bit product over a valid/ready handshake.
module booth_seq_mul16 #(
    parameter bit EARLY_TERM = 1'b0,
    parameter int NUM_GROUPS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_a_signed,
    input  logic        in_b_signed,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [16:0] a_q, a_d;
    logic [18:0] b_q, b_d;
    logic [33:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] prod_q, prod_d;

    logic        p2, p1, p0;
    logic        neg, one, two, ext;
    logic [17:0] g, pp_mag;
    logic [33:0] pp_sh, inj, acc_nx;
    logic [4:0]  sh;
    logic        last;
    logic        a_ext, b_ext;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_prod  = prod_q;

    assign a_ext = in_a_signed & in_a[15];
    assign b_ext = in_b_signed & in_b[15];

    // b_q shifts right by two each group, so the current triplet is always b_q[2:0]
    assign {p2, p1, p0} = b_q[2:0];

    always_comb begin
        neg    = p2 & ~(p1 & p0);
        one    = p1 ^ p0;
        two    = (p2 & ~p1 & ~p0) | (~p2 & p1 & p0);
        g      = one ? {a_q[16], a_q} : (two ? {a_q, 1'b0} : 18'd0);
        pp_mag = g ^ {18{neg}};
        ext    = pp_mag[17];
        sh     = {idx_q, 1'b0};
        pp_sh  = {{16{ext}}, pp_mag} << sh;
        inj    = 34'(neg) << sh;
        acc_nx = acc_q + pp_sh + inj;
        // Remaining digits are all zero once the upper multiplier bits are uniform
        last   = (idx_q == 4'(NUM_GROUPS - 1)) ||
                 (EARLY_TERM && (b_q[18:2] == {17{b_q[2]}}));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        prod_d  = prod_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = RUN;
                        a_d     = {a_ext, in_a};
                        b_d     = {b_ext, b_ext, in_b, 1'b0};
                        acc_d   = '0;
                        idx_d   = '0;
                    end
                end
                RUN: begin
                    acc_d = acc_nx;
                    b_d   = {b_q[18], b_q[18], b_q[18:2]};
                    idx_d = idx_q + 4'd1;
                    if (last) begin
                        state_d = DONE;
                        prod_d  = acc_nx[31:0];
                        idx_d   = '0;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            prod_q  <= prod_d;
        end
    end

    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        idx_q <= 4'(NUM_GROUPS - 1));

endmodule

// File: tb/tb_booth_seq_mul16.sv
// Directed and random checks of booth_seq_mul16, with full-run and
// early-terminate instances driven side by side.
module tb_booth_seq_mul16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_a_signed = 1'b0;
    logic        in_b_signed = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_prod0, out_prod1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_seq_mul16 #(.EARLY_TERM(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed),
        .in_b_signed(in_b_signed), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_prod(out_prod0), .busy(busy0)
    );

    booth_seq_mul16 #(.EARLY_TERM(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed),
        .in_b_signed(in_b_signed), .flush(flush), .out_valid(out_valid1),
        .out_ready(out_ready), .out_prod(out_prod1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gold(input logic [15:0] a, input logic [15:0] b,
                                         input logic as_, input logic bs_);
        longint x, y;
        x = as_ ? longint'($signed(a)) : longint'(a);
        y = bs_ ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic as_, input logic bs_,
                          output logic [31:0] p0, output logic [31:0] p1,
                          output int l0, output int l1);
        bit s0, s1;
        s0 = 0; s1 = 0; l0 = 99; l1 = 99; p0 = '0; p1 = '0;
        in_a = a; in_b = b; in_a_signed = as_; in_b_signed = bs_;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 30 && !(s0 && s1); k++) begin
            tick();
            if (!s0 && out_valid0) begin s0 = 1; p0 = out_prod0; l0 = k; end
            if (!s1 && out_valid1) begin s1 = 1; p1 = out_prod1; l1 = k; end
        end
        tick();
    endtask

    task automatic dir_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic as_,
                          input logic bs_, input logic [31:0] exp);
        logic [31:0] p0, p1;
        int l0, l1;
        run_op(a, b, as_, bs_, p0, p1, l0, l1);
        check({tag, "_p0"}, p0, exp);
        check({tag, "_p1"}, p1, exp);
        check({tag, "_lat0"}, 32'(l0), 32'd9);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] p0, p1, hold, e;
        int l0, l1, rises;
        logic [15:0] ra, rb;
        logic ras, rbs;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_out_prod", out_prod0, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready0), 32'd1);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, p0, p1, l0, l1);
        check("uu_ffff_p0", p0, 32'hFFFE0001);
        check("uu_ffff_p1", p1, 32'hFFFE0001);
        check("uu_ffff_lat0", 32'(l0), 32'd9);
        check("uu_ffff_in_ready", 32'(in_ready0), 32'd1);
        check("uu_ffff_busy", 32'(busy0), 32'd0);

        dir_op("ss_8000_8000", 16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000);
        dir_op("ss_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1'b1, 32'hC0008000);
        dir_op("ss_ffff_0001", 16'hFFFF, 16'h0001, 1'b1, 1'b1, 32'hFFFFFFFF);
        dir_op("su_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001);
        dir_op("us_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFF0001);

        // Backpressure
        in_a = 16'h8000; in_b = 16'h7FFF; in_a_signed = 1; in_b_signed = 1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 30 && !out_valid0; k++) tick();
        check("bp_valid", 32'(out_valid0), 32'd1);
        hold = out_prod0;
        check("bp_prod", hold, 32'hC0008000);
        in_a = 16'h0003; in_b = 16'h0005; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_prod", out_prod0, 32'hC0008000);
            check("bp_hold_ready", 32'(in_ready0), 32'd0);
            check("bp_hold_valid", 32'(out_valid0), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_rel_valid", 32'(out_valid0), 32'd0);
        check("bp_rel_ready", 32'(in_ready0), 32'd1);

        // Flush in RUN cycle 4
        in_a = 16'h1234; in_b = 16'h5678; in_a_signed = 0; in_b_signed = 0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid0), 32'd0);
        check("fl_ready", 32'(in_ready0), 32'd1);
        check("fl_busy1", 32'(busy1), 32'd0);
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid0 || out_valid1) rises++;
        end
        check("fl_no_valid", 32'(rises), 32'd0);

        // Reset mid-RUN
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(out_valid0), 32'd0);
        check("mr_ready", 32'(in_ready0), 32'd1);
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid0 || out_valid1) rises++;
        end
        check("mr_no_valid", 32'(rises), 32'd0);

        dir_op("uu_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 32'h06260060);

        run_op(16'h00FF, 16'h0003, 1'b0, 1'b0, p0, p1, l0, l1);
        check("et_p1", p1, 32'h000002FD);
        check("et_lat1", 32'(l1), 32'd2);
        check("et_p0", p0, 32'h000002FD);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n % 8 == 0) rb = 16'($urandom_range(0, 15));
            if (n % 8 == 1) rb = 16'hFFFF - 16'($urandom_range(0, 15));
            ras = 1'($urandom);
            rbs = 1'($urandom);
            e = gold(ra, rb, ras, rbs);
            run_op(ra, rb, ras, rbs, p0, p1, l0, l1);
            check("rnd_p0", p0, e);
            check("rnd_p1", p1, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
